// File: rtl/gpio_scan_ctrl.sv
// Board GPIO test-pattern sequencer: STOP / RUN (walking one) / HOLD / STEP over a valid/ready command port.
// One-hot 32-bit pin drive with a compile-time skip mask for pins borrowed by other board functions.
module gpio_scan_ctrl #(
  parameter int unsigned DWELL_BITS = 22,
  parameter logic [31:0] SKIP_MASK  = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_arg,
  output logic [31:0] gpio_out,
  output logic [4:0]  cur_idx,
  output logic        busy,
  output logic        wrap_pulse
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  localparam logic [1:0] OP_STOP = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_HOLD = 2'd2;
  localparam logic [1:0] OP_STEP = 2'd3;
  localparam logic       ALL_MASKED = &SKIP_MASK;

  state_t                state;
  logic [1:0]            op_q;
  logic [4:0]            arg_q;
  logic [DWELL_BITS-1:0] dwell;
  logic                  accept;
  logic [4:0]            first_idx;
  logic [4:0]            nxt_idx;
  logic                  nxt_wrap;

  assign cmd_ready = (state != LOAD);
  assign accept    = cmd_valid && cmd_ready;

  // Lowest unmasked index; falls back to 0 when everything is masked.
  always_comb begin
    first_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (!SKIP_MASK[i]) first_idx = 5'(i);
    end
  end

  // nxt(cur_idx): lowest unmasked index above cur_idx, else wrap to first_idx.
  always_comb begin
    nxt_idx  = first_idx;
    nxt_wrap = 1'b1;
    for (int i = 31; i >= 0; i--) begin
      if (!SKIP_MASK[i] && (i > int'(cur_idx))) begin
        nxt_idx  = 5'(i);
        nxt_wrap = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= OP_STOP;
      arg_q      <= '0;
      dwell      <= '0;
      gpio_out   <= '0;
      cur_idx    <= '0;
      busy       <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (accept) begin
        // A new command beats a coincident dwell terminal count; gpio_out is held through LOAD.
        state <= LOAD;
        op_q  <= cmd_op;
        arg_q <= cmd_arg;
        busy  <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            dwell <= '0;
            case (op_q)
              OP_RUN: begin
                if (ALL_MASKED) begin
                  state    <= IDLE;
                  gpio_out <= '0;
                end else begin
                  state    <= RUN;
                  cur_idx  <= first_idx;
                  gpio_out <= 32'd1 << first_idx;
                  busy     <= 1'b1;
                end
              end
              OP_HOLD: begin
                if (SKIP_MASK[arg_q]) begin
                  state    <= IDLE;
                  gpio_out <= '0;
                end else begin
                  state    <= HOLD;
                  cur_idx  <= arg_q;
                  gpio_out <= 32'd1 << arg_q;
                  busy     <= 1'b1;
                end
              end
              OP_STEP: begin
                if (ALL_MASKED) begin
                  state    <= IDLE;
                  gpio_out <= '0;
                end else begin
                  state    <= HOLD;
                  cur_idx  <= nxt_idx;
                  gpio_out <= 32'd1 << nxt_idx;
                  busy     <= 1'b1;
                end
              end
              default: begin
                state    <= IDLE;
                gpio_out <= '0;
              end
            endcase
          end
          RUN: begin
            dwell <= dwell + 1'b1;
            if (&dwell) begin
              cur_idx    <= nxt_idx;
              gpio_out   <= 32'd1 << nxt_idx;
              wrap_pulse <= nxt_wrap;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/gpio_scan_ctrl.md
Name: gpio_scan_ctrl

Overview:
- Sequencing controller for the board GPIO test pattern.
- Accepts simple commands over a valid/ready handshake:
  - STOP: all outputs off.
  - RUN: walking-one auto-scan.
  - HOLD: park on one chosen pin.
  - STEP: advance one pin and hold.
- Drives a registered 32-bit one-hot pin vector, indexed in the same 0x00–0x1F sequence order the top level maps to physical gpio_* pins.
- Honours a skip mask so pins borrowed for other uses (e.g. index 0x0E when the OSC jumper routes the 12 MHz clock) are never driven.

Parameters:
- DWELL_BITS, 22: each pin is dwelled on for 2**DWELL_BITS clk cycles in RUN. Benches override this to 3.
- SKIP_MASK, 32'h0000_4000: bit i=1 means index i is never driven or selected.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command this cycle
- cmd_op  input  2  0=STOP, 1=RUN, 2=HOLD, 3=STEP
- cmd_arg  input  5  pin index for HOLD; ignored otherwise
- gpio_out  output  32  registered one-hot (or zero) pin drive, bit i = sequence index i
- cur_idx  output  5  currently selected index (registered)
- busy  output  1  1 in RUN or HOLD
- wrap_pulse  output  1  one-cycle pulse when RUN advances from the highest unmasked index to the lowest

Behaviour:
- Reset: one clk and one synchronous, active-high reset. With reset high at a clk edge:
  - state=IDLE; gpio_out=0; cur_idx=0; busy=0; wrap_pulse=0; cmd_ready=1; dwell counter=0.
  - Reset overrides any command presented in the same cycle.
  - Reset mid-RUN or mid-HOLD clears gpio_out on the next edge, with no partial dwell retained.
- States:
  - IDLE: outputs off.
  - LOAD: 1 cycle; applies the accepted command.
  - RUN: dwell counter counts; advances on terminal count.
  - HOLD: fixed pin.
- Handshake:
  - Accept occurs when cmd_valid && cmd_ready at a clk edge.
  - cmd_ready=0 only in LOAD. Every accepted command passes through LOAD.
  - The command fields are captured at accept. Later changes to cmd_arg/cmd_op have no effect.
- Latency: accept at edge N; state=LOAD after N; gpio_out/cur_idx/busy reflect the command after edge N+1.
- Next-index function nxt(i):
  - Returns the lowest unmasked index greater than i.
  - If none exists, returns the lowest unmasked index overall (this is a wrap).
  - If all 32 indices are masked (SKIP_MASK=all ones), a "none" flag is set.
- Effect of each command, applied in LOAD:
  - STOP: go to IDLE. gpio_out=0, cur_idx unchanged, dwell=0.
  - RUN:
    - If "none" is set, go to IDLE.
    - Otherwise cur_idx = lowest unmasked index, gpio_out = 1<<cur_idx, dwell=0, go to RUN.
  - HOLD:
    - If cmd_arg is masked, behave as STOP: IDLE, gpio_out=0.
    - Otherwise cur_idx = cmd_arg, gpio_out = 1<<cmd_arg, go to HOLD.
  - STEP:
    - If "none" is set, go to IDLE.
    - Otherwise cur_idx = nxt(cur_idx), gpio_out = 1<<nxt(cur_idx), go to HOLD. This holds from IDLE too.
- RUN dwell:
  - The DWELL_BITS counter increments every cycle in RUN.
  - At all-ones it wraps to 0, and on that same edge cur_idx = nxt(cur_idx) and gpio_out updates.
  - Each index is therefore driven for exactly 2**DWELL_BITS cycles; the first index also gets the same full dwell after LOAD.
  - wrap_pulse=1 for the single cycle following an advance where nxt wrapped.
- Simultaneous events: a command accepted on the same edge the dwell reaches terminal count wins. No advance occurs; the state goes to LOAD.
- Output invariants:
  - gpio_out is never multi-hot.
  - gpio_out & SKIP_MASK == 0 always.
  - gpio_out is 0 in IDLE and LOAD-from-IDLE. In LOAD from RUN/HOLD it keeps its previous value.

Test Plan:
1. Reset and defaults: assert reset 2 cycles, DWELL_BITS=3 -> gpio_out=0, cur_idx=0, busy=0, cmd_ready=1.
2. RUN scan: issue RUN -> cmd_ready=0 for 1 cycle.
   - gpio_out=32'h1 two edges after accept.
   - Advances every 8 cycles: 0x1, 0x2, …, 0x2000, then 0x8000 (index 14 skipped), …, 0x8000_0000, then back to 0x1.
   - wrap_pulse high exactly 1 cycle at the return to index 0.
3. HOLD and mask: HOLD arg=5 -> gpio_out=32'h20 held for 100 cycles with no advance. HOLD arg=14 -> gpio_out=0, busy=0.
4. STEP: from HOLD idx 13, STEP -> idx 15 (gpio_out=32'h8000). STEP at idx 31 -> idx 0, and wrap_pulse stays 0 in HOLD.
5. Collision and reset: RUN, then present STOP exactly on a dwell terminal edge -> no advance, IDLE, gpio_out=0. Assert reset mid-RUN -> all outputs at reset values next edge, and a command presented with reset is ignored.
6. All-masked build: SKIP_MASK=32'hFFFF_FFFF, RUN and STEP -> stays IDLE, gpio_out=0 throughout.
